// File: rtl/display_scan_ctrl_if.sv
// Bus between the display scan controller and its environment.
//   sw        : raw switch code, bit4 = C1 ... bit0 = C5
//   req       : request to evaluate the current switch code
//   code_out  : code driven onto the display datapath (C1..C5)
//   seg_in    : datapath outputs, bit3 = A ... bit0 = D
//   res_out   : latched datapath result
//   res_code  : code that produced res_out
//   res_valid : result available, held until res_ack
//   res_ack   : consumer acknowledge
//   busy      : controller not idle
// Modports: slave = controller side, master = environment side.
interface display_scan_ctrl_if;
  logic [4:0] sw;
  logic       req;
  logic [4:0] code_out;
  logic [3:0] seg_in;
  logic [3:0] res_out;
  logic [4:0] res_code;
  logic       res_valid;
  logic       res_ack;
  logic       busy;

  modport slave (
    input  sw, req, seg_in, res_ack,
    output code_out, res_out, res_code, res_valid, busy
  );

  modport master (
    output sw, req, seg_in, res_ack,
    input  code_out, res_out, res_code, res_valid, busy
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Display scan controller: on request, (optionally) debounces the switch code, drives it onto the
// display datapath, waits for the datapath to settle, then latches and holds the result until
// acknowledged.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : display_scan_ctrl_if.slave (sw, req, seg_in, res_ack in; code_out, res_out, res_code,
//         res_valid, busy out)
// Parameters:
//   SETTLE     : datapath settle time in cycles (>= 1)
//   DEB_CYCLES : consecutive stable cycles needed to accept a switch code (>= 1)
// Configuration:
//   DISPLAY_SCAN_CTRL_DEBOUNCE_EN : when defined, adds the DEBOUNCE state between IDLE and DRIVE;
//   when undefined, IDLE drives the raw switch code straight away.
module display_scan_ctrl #(
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned DEB_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  display_scan_ctrl_if.slave  bus
);

  localparam int unsigned MaxCnt = (SETTLE > DEB_CYCLES) ? SETTLE : DEB_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDrive    = 2'd2;
  localparam logic [1:0] StHold     = 2'd3;
`ifdef DISPLAY_SCAN_CTRL_DEBOUNCE_EN
  localparam logic [1:0] StDebounce = 2'd1;
  localparam logic [CntW-1:0] DebLast = CntW'(DEB_CYCLES - 1);
`endif

  logic [1:0]      r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]      r_code, w_code_nxt;
  logic [3:0]      r_res, w_res_nxt;
  logic [4:0]      r_res_code, w_res_code_nxt;
  logic            r_valid, w_valid_nxt;
`ifdef DISPLAY_SCAN_CTRL_DEBOUNCE_EN
  logic [4:0]      r_sw_q, w_sw_q_nxt;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_code_nxt     = r_code;
    w_res_nxt      = r_res;
    w_res_code_nxt = r_res_code;
    w_valid_nxt    = r_valid;
`ifdef DISPLAY_SCAN_CTRL_DEBOUNCE_EN
    w_sw_q_nxt     = r_sw_q;
`endif
    case (r_state)
      StIdle: begin
        if (bus.req) begin
          w_cnt_nxt   = '0;
`ifdef DISPLAY_SCAN_CTRL_DEBOUNCE_EN
          w_sw_q_nxt  = bus.sw;
          w_state_nxt = StDebounce;
`else
          w_code_nxt  = bus.sw;
          w_state_nxt = StDrive;
`endif
        end
      end
`ifdef DISPLAY_SCAN_CTRL_DEBOUNCE_EN
      StDebounce: begin
        // Any change restarts the stability window with the new code.
        if (bus.sw != r_sw_q) begin
          w_sw_q_nxt = bus.sw;
          w_cnt_nxt  = '0;
        end else if (r_cnt == DebLast) begin
          w_code_nxt  = r_sw_q;
          w_cnt_nxt   = '0;
          w_state_nxt = StDrive;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
`endif
      StDrive: begin
        if (r_cnt == SettleLast) begin
          w_res_nxt      = bus.seg_in;
          w_res_code_nxt = r_code;
          w_valid_nxt    = 1'b1;
          w_cnt_nxt      = '0;
          w_state_nxt    = StHold;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      StHold: begin
        if (bus.res_ack) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_code     <= '0;
      r_res      <= '0;
      r_res_code <= '0;
      r_valid    <= 1'b0;
`ifdef DISPLAY_SCAN_CTRL_DEBOUNCE_EN
      r_sw_q     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_code     <= w_code_nxt;
      r_res      <= w_res_nxt;
      r_res_code <= w_res_code_nxt;
      r_valid    <= w_valid_nxt;
`ifdef DISPLAY_SCAN_CTRL_DEBOUNCE_EN
      r_sw_q     <= w_sw_q_nxt;
`endif
    end
  end

  assign bus.code_out  = r_code;
  assign bus.res_out   = r_res;
  assign bus.res_code  = r_res_code;
  assign bus.res_valid = r_valid;
  assign bus.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed testbench for display_scan_ctrl. Datapath model: A = ~C1, B..D = 0.
// Works for both builds; latency to DRIVE is DEB_CYCLES with DISPLAY_SCAN_CTRL_DEBOUNCE_EN, else 0.
module tb_display_scan_ctrl;
  localparam int unsigned SETTLE     = 2;
  localparam int unsigned DEB_CYCLES = 4;
`ifdef DISPLAY_SCAN_CTRL_DEBOUNCE_EN
  localparam int unsigned L = DEB_CYCLES;
`else
  localparam int unsigned L = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [4:0] exp_code;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(
    .SETTLE     (SETTLE),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_seg(input logic [4:0] c);
    return {~c[4], 3'b000};
  endfunction

  assign bus.seg_in = model_seg(bus.code_out);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 1'b0; bus.res_ack = 1'b0; bus.sw = 5'b10101;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.code_out !== 5'b0) begin
      failures++; $display("FAIL reset_code_out got=%b exp=%b", bus.code_out, 5'b0);
    end
    checks++;
    if (bus.res_out !== 4'b0) begin
      failures++; $display("FAIL reset_res_out got=%b exp=%b", bus.res_out, 4'b0);
    end
    checks++;
    if (bus.res_code !== 5'b0) begin
      failures++; $display("FAIL reset_res_code got=%b exp=%b", bus.res_code, 5'b0);
    end
    checks++;
    if ({bus.res_valid, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL reset_valid_busy got=%b exp=00", {bus.res_valid, bus.busy});
    end
    exp_code = 5'b0;
  endtask

  task automatic test_latency();
    logic [4:0] codes [3];
    logic [4:0] c;
    codes[0] = 5'b00000; codes[1] = 5'b10000; codes[2] = 5'b01110;
    for (int n = 0; n < 3; n++) begin
      c = codes[n];
      bus.sw = c; bus.req = 1'b1;
      tick();  // edge k
      bus.req = 1'b0;
      checks++;
      if ({bus.busy, bus.code_out} !== {1'b1, (L == 0) ? c : exp_code}) begin
        failures++;
        $display("FAIL lat_edge_k busy,code got=%b exp=%b", {bus.busy, bus.code_out},
                 {1'b1, (L == 0) ? c : exp_code});
      end
      for (int i = 1; i <= L; i++) begin
        tick();
        if (i < L) begin
          checks++;
          if (bus.code_out !== exp_code) begin
            failures++; $display("FAIL lat_code_early got=%b exp=%b", bus.code_out, exp_code);
          end
        end
      end
      checks++;
      if (bus.code_out !== c) begin
        failures++; $display("FAIL lat_code_drive got=%b exp=%b", bus.code_out, c);
      end
      repeat (SETTLE - 1) tick();
      checks++;
      if (bus.res_valid !== 1'b0) begin
        failures++; $display("FAIL lat_valid_early got=%b exp=0", bus.res_valid);
      end
      tick();
      checks++;
      if ({bus.res_valid, bus.busy, bus.res_out, bus.res_code} !== {2'b11, model_seg(c), c}) begin
        failures++;
        $display("FAIL lat_result got=%b exp=%b", {bus.res_valid, bus.busy, bus.res_out,
                 bus.res_code}, {2'b11, model_seg(c), c});
      end
      bus.res_ack = 1'b1;
      tick();
      bus.res_ack = 1'b0;
      checks++;
      if ({bus.res_valid, bus.busy} !== 2'b00) begin
        failures++; $display("FAIL lat_ack got=%b exp=00", {bus.res_valid, bus.busy});
      end
      exp_code = c;
    end
  endtask

  task automatic test_sw_change();
    bus.sw = 5'b10000; bus.req = 1'b1;
    tick();  // edge k
    bus.req = 1'b0;
    tick();  // k+1
    bus.sw = 5'b00011;
    tick();  // k+2
`ifdef DISPLAY_SCAN_CTRL_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.code_out !== exp_code) begin
        failures++; $display("FAIL swchg_code_early got=%b exp=%b", bus.code_out, exp_code);
      end
    end
    tick();  // k+6
    checks++;
    if (bus.code_out !== 5'b00011) begin
      failures++; $display("FAIL swchg_code got=%b exp=00011", bus.code_out);
    end
    repeat (2) tick();  // k+8
    checks++;
    if ({bus.res_valid, bus.res_out, bus.res_code} !== {1'b1, 4'b1000, 5'b00011}) begin
      failures++;
      $display("FAIL swchg_result got=%b exp=%b", {bus.res_valid, bus.res_out, bus.res_code},
               {1'b1, 4'b1000, 5'b00011});
    end
    exp_code = 5'b00011;
`else
    checks++;
    if ({bus.res_valid, bus.res_out, bus.res_code, bus.code_out} !==
        {1'b1, 4'b0000, 5'b10000, 5'b10000}) begin
      failures++;
      $display("FAIL swchg_result got=%b exp=%b", {bus.res_valid, bus.res_out, bus.res_code,
               bus.code_out}, {1'b1, 4'b0000, 5'b10000, 5'b10000});
    end
    exp_code = 5'b10000;
`endif
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
  endtask

  task automatic test_hold();
    logic got_valid;
    bus.sw = 5'b00101; bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    repeat (L + SETTLE - 1) tick();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL hold_valid_early got=%b exp=0", bus.res_valid);
    end
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.req = (i < 5); bus.sw = 5'b11111; bus.res_ack = 1'b0;
      tick();
      checks++;
      if ({bus.res_valid, bus.busy, bus.res_out, bus.res_code, bus.code_out} !==
          {2'b11, 4'b1000, 5'b00101, 5'b00101}) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got=%b exp=%b", i, {bus.res_valid, bus.busy,
                 bus.res_out, bus.res_code, bus.code_out}, {2'b11, 4'b1000, 5'b00101, 5'b00101});
      end
    end
    bus.req = 1'b0; bus.res_ack = 1'b1;
    tick();  // edge n
    bus.res_ack = 1'b0;
    checks++;
    if ({bus.res_valid, bus.busy, bus.code_out} !== {2'b00, 5'b00101}) begin
      failures++;
      $display("FAIL hold_ack got=%b exp=%b", {bus.res_valid, bus.busy, bus.code_out},
               {2'b00, 5'b00101});
    end
    bus.sw = 5'b10000; bus.req = 1'b1;
    tick();  // edge n+1
    bus.req = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL hold_new_req busy got=%b exp=1", bus.busy);
    end
    got_valid = 1'b0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      tick();
      got_valid = bus.res_valid;
    end
    checks++;
    if ({got_valid, bus.res_out, bus.res_code} !== {1'b1, 4'b0000, 5'b10000}) begin
      failures++;
      $display("FAIL hold_new_result got=%b exp=%b", {got_valid, bus.res_out, bus.res_code},
               {1'b1, 4'b0000, 5'b10000});
    end
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
    exp_code = 5'b10000;
  endtask

  task automatic test_ack_ignored();
    bus.res_ack = 1'b1;
    tick();
    checks++;
    if ({bus.res_valid, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL ackign_idle got=%b exp=00", {bus.res_valid, bus.busy});
    end
    bus.sw = 5'b01000; bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    repeat (L + SETTLE - 1) tick();
    checks++;
    if ({bus.res_valid, bus.busy} !== 2'b01) begin
      failures++; $display("FAIL ackign_busy got=%b exp=01", {bus.res_valid, bus.busy});
    end
    tick();
    checks++;
    if ({bus.res_valid, bus.res_out, bus.res_code} !== {1'b1, 4'b1000, 5'b01000}) begin
      failures++;
      $display("FAIL ackign_result got=%b exp=%b", {bus.res_valid, bus.res_out, bus.res_code},
               {1'b1, 4'b1000, 5'b01000});
    end
    tick();
    bus.res_ack = 1'b0;
    checks++;
    if ({bus.res_valid, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL ackign_hold_ack got=%b exp=00", {bus.res_valid, bus.busy});
    end
    exp_code = 5'b01000;
  endtask

  task automatic test_reset_in_drive();
    logic seen;
    bus.sw = 5'b11111; bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    repeat (L) tick();
    checks++;
    if ({bus.busy, bus.code_out} !== {1'b1, 5'b11111}) begin
      failures++;
      $display("FAIL rstdrv_enter got=%b exp=%b", {bus.busy, bus.code_out}, {1'b1, 5'b11111});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.res_valid, bus.busy, bus.code_out, bus.res_out, bus.res_code} !== 16'b0) begin
      failures++;
      $display("FAIL rstdrv_reset got=%b exp=%b", {bus.res_valid, bus.busy, bus.code_out,
               bus.res_out, bus.res_code}, 16'b0);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | bus.res_valid | bus.busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rstdrv_no_result got=%b exp=0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sw = '0; bus.req = 1'b0; bus.res_ack = 1'b0; rst = 1'b1;
    exp_code = '0;
    test_reset();
    test_latency();
    test_sw_change();
    test_hold();
    test_ack_ignored();
    test_reset_in_drive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter: SETTLE, 2, datapath settle time in clock cycles (legal range >= 1).
REQ-002 Parameter: DEB_CYCLES, 4, number of consecutive stable cycles a switch code needs before acceptance (legal range >= 1).
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: sw  in  5  raw switch code; bit4 = C1 ... bit0 = C5.
REQ-006 Port: req  in  1  request to evaluate the current switch code; sampled only in IDLE.
REQ-007 Port: code_out  out  5  drives C1..C5 of the display datapath, with the same bit order as sw.
REQ-008 Port: seg_in  in  4  datapath outputs A..D; bit3 = A ... bit0 = D.
REQ-009 Port: res_out  out  4  latched datapath result.
REQ-010 Port: res_code  out  5  the code that produced res_out.
REQ-011 Port: res_valid  out  1  result available; held high until acknowledged.
REQ-012 Port: res_ack  in  1  consumer acknowledge; meaningful only while res_valid=1.
REQ-013 Port: busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, DEBOUNCE, DRIVE and HOLD.
REQ-015 IDLE, req=1: enter DEBOUNCE and load sw_q<=sw, cnt<=0 (debounce build); otherwise see REQ-025.
REQ-016 DEBOUNCE, each edge: if sw!=sw_q, then sw_q<=sw and cnt<=0; otherwise, if cnt==DEB_CYCLES-1, then code_out<=sw_q, cnt<=0 and enter DRIVE; otherwise cnt++.
REQ-017 DRIVE, each edge: if cnt==SETTLE-1, then res_out<=seg_in, res_code<=code_out, res_valid<=1 and enter HOLD; otherwise cnt++.
REQ-018 HOLD: res_out, res_code and res_valid SHALL stay stable until res_ack=1 is sampled; on that edge res_valid<=0 and the FSM enters IDLE.
REQ-019 req SHALL be ignored in DEBOUNCE, DRIVE and HOLD; it is neither queued nor counted.
REQ-020 res_ack SHALL be ignored outside HOLD.
REQ-021 code_out SHALL keep its last value across all states; it changes only on the transition into DRIVE.
REQ-022 Latency with stable sw (debounce build): req sampled at edge k; code_out updates at edge k+DEB_CYCLES; res_valid rises at edge k+DEB_CYCLES+SETTLE.
REQ-023 Counter cnt SHALL be wide enough for max(SETTLE, DEB_CYCLES)-1 and SHALL never wrap.

Reset
REQ-024 While rst=1 at an edge, in any state: FSM<=IDLE, cnt<=0, sw_q<=0, code_out<=0, res_out<=0, res_code<=0, res_valid<=0; busy=0 follows. rst SHALL take priority over req and res_ack. Any in-flight operation SHALL be abandoned with no result.

Configuration
REQ-025 Macro DISPLAY_SCAN_CTRL_DEBOUNCE_EN.
- Defined: DEBOUNCE exists and behaves as REQ-015/016.
- Undefined: DEBOUNCE, sw_q and its logic are absent; IDLE with req=1 does code_out<=sw, cnt<=0 and enters DRIVE; res_valid rises at edge k+SETTLE.

Verification (SETTLE=2, DEB_CYCLES=4; datapath model drives A per its equation, B..D=0)
REQ-026 rst high for 3 edges, then low with no req -> all outputs 0 and FSM in IDLE.
REQ-027 No-debounce build, sw=5'b00000, req at edge 10 -> code_out=00000 at edge 10; res_valid=1, res_out=4'b1000, res_code=00000 at edge 12.
REQ-028 Debounce build, sw=5'b10000 stable, req at edge 10 -> code_out=10000 at edge 14; res_valid at edge 16 with res_out=4'b0000.
REQ-029 Debounce build, req at edge 10, sw changes 10000->00011 at edge 12 then stays stable -> code_out=00011 at edge 16; res_out=4'b1000 at edge 18.
REQ-030 In HOLD, req pulses for 5 cycles and res_ack is withheld 7 cycles -> res_valid and results unchanged; ack at edge n clears res_valid and enters IDLE at edge n; a new req at edge n+1 is accepted.
REQ-031 rst asserted at the first DRIVE edge -> res_valid stays 0, code_out=0 and busy=0 at the reset edge; no result appears later.
